// File: rtl/systolic_pkg.sv
// systolic_pkg -- shared types and arithmetic for the systolic processing element.
//   pe_mode_e  : operating mode (output-stationary / weight-stationary)
//   pe_state_e : output-stationary sequencing states
//   sat_add    : add with overflow detection and optional clamping, returns {ovf, sum}
package systolic_pkg;

  typedef enum logic {
    MODE_OS = 1'b0,
    MODE_WS = 1'b1
  } pe_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } pe_state_e;

  // Internal working width of sat_add; accumulator widths up to 62 bits are safe.
  localparam int SUM_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [SUM_W-1:0] sum;
  } sat_res_t;

  // a and b must already be sign- (signed_mode) or zero-extended to SUM_W.
  // The result is the width-bit sum (sign-extended when signed), clamped when
  // saturate is set and the true sum does not fit in width bits.
  function automatic sat_res_t sat_add(input logic [SUM_W-1:0] a,
                                       input logic [SUM_W-1:0] b,
                                       input int unsigned      width,
                                       input logic             signed_mode,
                                       input logic             saturate);
    logic [SUM_W-1:0] mask;
    logic [SUM_W-1:0] msb;
    logic [SUM_W-1:0] raw;
    logic [SUM_W-1:0] low;
    logic [SUM_W-1:0] wrapped;
    logic [SUM_W-1:0] bound;
    sat_res_t         res;
    mask = (64'd1 << width) - 64'd1;
    msb  = 64'd1 << (width - 1);
    raw  = a + b;
    low  = raw & mask;
    if (signed_mode) begin
      wrapped = ((low & msb) != '0) ? (low | ~mask) : low;
      res.ovf = (wrapped != raw);
      // raw never wraps at SUM_W, so its top bit tells the overflow direction
      bound   = raw[SUM_W-1] ? (~mask | msb) : (mask >> 1);
    end else begin
      wrapped = low;
      res.ovf = ((raw & ~mask) != '0);
      bound   = mask;
    end
    res.sum = (res.ovf && saturate) ? bound : wrapped;
    return res;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// pe_mac_unit -- combinational multiply-add for one systolic cell.
//   mul_a, mul_b : DATA_WIDTH operands (signed or unsigned per SIGNED)
//   addend       : ACC_WIDTH value added to the product
//   sum          : ACC_WIDTH result, wrapped or clamped per SATURATE
//   ovf          : the add overflowed ACC_WIDTH
module pe_mac_unit
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] mul_a,
  input  logic [DATA_WIDTH-1:0] mul_b,
  input  logic [ACC_WIDTH-1:0]  addend,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [SUM_W-1:0]           prod_ext;
  logic [SUM_W-1:0]           addend_ext;
  sat_res_t                   res;
  logic [SUM_W-ACC_WIDTH-1:0] unused_sum_hi;

  generate
    if (SIGNED) begin : g_signed
      logic signed [PW-1:0] a_x;
      logic signed [PW-1:0] b_x;
      logic signed [PW-1:0] p_x;
      assign a_x        = {{DATA_WIDTH{mul_a[DATA_WIDTH-1]}}, mul_a};
      assign b_x        = {{DATA_WIDTH{mul_b[DATA_WIDTH-1]}}, mul_b};
      assign p_x        = a_x * b_x;
      assign prod_ext   = {{(SUM_W-PW){p_x[PW-1]}}, p_x};
      assign addend_ext = {{(SUM_W-ACC_WIDTH){addend[ACC_WIDTH-1]}}, addend};
    end else begin : g_unsigned
      logic [PW-1:0] a_x;
      logic [PW-1:0] b_x;
      logic [PW-1:0] p_x;
      assign a_x        = {{DATA_WIDTH{1'b0}}, mul_a};
      assign b_x        = {{DATA_WIDTH{1'b0}}, mul_b};
      assign p_x        = a_x * b_x;
      assign prod_ext   = {{(SUM_W-PW){1'b0}}, p_x};
      assign addend_ext = {{(SUM_W-ACC_WIDTH){1'b0}}, addend};
    end
  endgenerate

  assign res           = sat_add(prod_ext, addend_ext, ACC_WIDTH, SIGNED, SATURATE);
  assign sum           = res.sum[ACC_WIDTH-1:0];
  assign ovf           = res.ovf;
  assign unused_sum_hi = res.sum[SUM_W-1:ACC_WIDTH];

endmodule

// File: rtl/systolic_pe_v2.sv
// systolic_pe_v2 -- one MAC cell of an R x C systolic array.
//   Output-stationary: accumulates top_in*left_in locally, then drains down the psum chain.
//   Weight-stationary: psum_out = psum_in + weight*left_in, one cycle later.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mode_ws                    0 = OS, 1 = WS (change only while idle)
//   clear                      sync tile restart: acc/ovf/psum outputs to 0, FSM to IDLE
//   w_load                     WS weight capture from top_in when top_vld
//   drain                      OS level request to drain the psum chain
//   top_in/top_vld             north operand, forwarded to bottom_out/bottom_vld
//   left_in/left_vld           west operand, forwarded to right_out/right_vld
//   psum_in/psum_in_vld        psum from north neighbour
//   psum_out/psum_out_vld      psum to south neighbour
//   ovf                        sticky overflow flag
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no tile in progress, acc is 0; also the only state used in WS
// ST_ACC   | OS accumulating valid operand pairs into acc
// ST_DRAIN | OS: acc has been emitted, psum_out shifts psum_in down
module systolic_pe_v2
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_ws,
  input  logic                  clear,
  input  logic                  w_load,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] top_in,
  input  logic                  top_vld,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic                  left_vld,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_in_vld,
  output logic [DATA_WIDTH-1:0] bottom_out,
  output logic                  bottom_vld,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  right_vld,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_out_vld,
  output logic                  ovf
);

  pe_mode_e              mode;
  pe_state_e             state_q;
  pe_state_e             state_d;
  logic [DATA_WIDTH-1:0] weight_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  pair_vld;
  logic                  os_acc_en;
  logic                  os_drain_entry;
  logic                  os_drain_shift;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [ACC_WIDTH-1:0]  mac_addend;
  logic [ACC_WIDTH-1:0]  mac_sum;
  logic                  mac_ovf;

  assign mode     = pe_mode_e'(mode_ws);
  assign pair_vld = top_vld & left_vld;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (clear || mode == MODE_WS) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (drain)         state_d = ST_DRAIN;
          else if (pair_vld) state_d = ST_ACC;
        end
        ST_ACC: begin
          if (drain) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs (datapath strobes) ----------------
  // drain outranks accumulation, so a valid pair on the drain entry cycle is dropped.
  always_comb begin
    os_acc_en      = 1'b0;
    os_drain_entry = 1'b0;
    os_drain_shift = 1'b0;
    if (!clear && mode == MODE_OS) begin
      unique case (state_q)
        ST_IDLE, ST_ACC: begin
          if (drain)         os_drain_entry = 1'b1;
          else if (pair_vld) os_acc_en      = 1'b1;
        end
        ST_DRAIN: begin
          if (drain) os_drain_shift = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- MAC ----------------
  // In IDLE acc is 0 by construction; forcing a zero addend makes the first
  // product load independent of any stale acc contents.
  always_comb begin
    mac_a      = top_in;
    mac_addend = '0;
    if (mode == MODE_WS) begin
      mac_a      = weight_q;
      mac_addend = psum_in;
    end else if (state_q == ST_ACC) begin
      mac_addend = acc_q;
    end
  end

  pe_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_mac (
    .mul_a  (mac_a),
    .mul_b  (left_in),
    .addend (mac_addend),
    .sum    (mac_sum),
    .ovf    (mac_ovf)
  );

  // ---------------- operand forwarding and weight ----------------
  // A weight being loaded is consumed here and not passed further south.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right_out  <= '0;
      right_vld  <= 1'b0;
      bottom_out <= '0;
      bottom_vld <= 1'b0;
      weight_q   <= '0;
    end else begin
      right_out  <= left_in;
      right_vld  <= left_vld;
      bottom_out <= top_in;
      bottom_vld <= (mode == MODE_WS && w_load) ? 1'b0 : top_vld;
      if (mode == MODE_WS && w_load && top_vld) weight_q <= top_in;
    end
  end

  // ---------------- accumulator, psum chain, overflow ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      psum_out     <= '0;
      psum_out_vld <= 1'b0;
      ovf          <= 1'b0;
    end else if (clear) begin
      acc_q        <= '0;
      psum_out     <= '0;
      psum_out_vld <= 1'b0;
      ovf          <= 1'b0;
    end else if (mode == MODE_WS) begin
      // without a valid left operand the psum passes through unchanged as a bubble
      psum_out     <= left_vld ? mac_sum : psum_in;
      psum_out_vld <= psum_in_vld & left_vld;
      if (psum_in_vld && left_vld && mac_ovf) ovf <= 1'b1;
    end else begin
      if (os_drain_entry) begin
        psum_out     <= acc_q;
        psum_out_vld <= 1'b1;
        acc_q        <= '0;
      end else if (os_drain_shift) begin
        psum_out     <= psum_in;
        psum_out_vld <= psum_in_vld;
      end else begin
        psum_out_vld <= 1'b0;
      end
      if (os_acc_en) begin
        acc_q <= mac_sum;
        if (mac_ovf) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_v2.sv
// tb_systolic_pe_v2 -- directed bench for systolic_pe_v2.
//   u_dut : DATA 8 / ACC 32, signed, saturating
//   u_s16 : ACC 16, saturating
//   u_w16 : ACC 16, wrapping
// All three cells see the same stimulus.
module tb_systolic_pe_v2;
  import systolic_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mode_ws;
  logic        clear;
  logic        w_load;
  logic        drain;
  logic [7:0]  top_in;
  logic        top_vld;
  logic [7:0]  left_in;
  logic        left_vld;
  logic [31:0] psum_in;
  logic        psum_in_vld;

  logic [7:0]  bottom_out, right_out;
  logic        bottom_vld, right_vld;
  logic [31:0] psum_out;
  logic        psum_out_vld, ovf;

  logic [7:0]  s_bottom_out, s_right_out, w_bottom_out, w_right_out;
  logic        s_bottom_vld, s_right_vld, w_bottom_vld, w_right_vld;
  logic [15:0] s_psum_out, w_psum_out;
  logic        s_psum_out_vld, s_ovf, w_psum_out_vld, w_ovf;

  int tests = 0;
  int fails = 0;

  systolic_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1'b1), .SATURATE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode_ws(mode_ws), .clear(clear), .w_load(w_load),
    .drain(drain), .top_in(top_in), .top_vld(top_vld), .left_in(left_in),
    .left_vld(left_vld), .psum_in(psum_in), .psum_in_vld(psum_in_vld),
    .bottom_out(bottom_out), .bottom_vld(bottom_vld), .right_out(right_out),
    .right_vld(right_vld), .psum_out(psum_out), .psum_out_vld(psum_out_vld), .ovf(ovf)
  );

  systolic_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .mode_ws(mode_ws), .clear(clear), .w_load(w_load),
    .drain(drain), .top_in(top_in), .top_vld(top_vld), .left_in(left_in),
    .left_vld(left_vld), .psum_in(psum_in[15:0]), .psum_in_vld(psum_in_vld),
    .bottom_out(s_bottom_out), .bottom_vld(s_bottom_vld), .right_out(s_right_out),
    .right_vld(s_right_vld), .psum_out(s_psum_out), .psum_out_vld(s_psum_out_vld), .ovf(s_ovf)
  );

  systolic_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .mode_ws(mode_ws), .clear(clear), .w_load(w_load),
    .drain(drain), .top_in(top_in), .top_vld(top_vld), .left_in(left_in),
    .left_vld(left_vld), .psum_in(psum_in[15:0]), .psum_in_vld(psum_in_vld),
    .bottom_out(w_bottom_out), .bottom_vld(w_bottom_vld), .right_out(w_right_out),
    .right_vld(w_right_vld), .psum_out(w_psum_out), .psum_out_vld(w_psum_out_vld), .ovf(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ops(input logic [7:0] t, input logic tv, input logic [7:0] l, input logic lv);
    top_in   = t;
    top_vld  = tv;
    left_in  = l;
    left_vld = lv;
  endtask

  initial begin
    rst_n = 1'b0; mode_ws = 1'b0; clear = 1'b0; w_load = 1'b0; drain = 1'b0;
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    psum_in = '0; psum_in_vld = 1'b0;

    // reset values
    #12;
    chk("rst_psum_out", 64'(psum_out), 64'h0);
    chk("rst_psum_vld", 64'(psum_out_vld), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_bottom_vld", 64'(bottom_vld), 64'h0);
    chk("rst_right_out", 64'(right_out), 64'h0);
    chk("rst_state", 64'(u_dut.state_q), 64'(ST_IDLE));
    chk("rst_acc", 64'(u_dut.acc_q), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // OS signed: 4 x (3,-2) -> -24
    ops(8'd3, 1'b1, 8'hFE, 1'b1);
    tick();
    chk("t1_right_out", 64'(right_out), 64'hFE);
    chk("t1_right_vld", 64'(right_vld), 64'h1);
    chk("t1_bottom_out", 64'(bottom_out), 64'h03);
    chk("t1_bottom_vld", 64'(bottom_vld), 64'h1);
    chk("t1_state_acc", 64'(u_dut.state_q), 64'(ST_ACC));
    chk("t1_acc_first", 64'(u_dut.acc_q), 64'hFFFF_FFFA);
    tick(); tick(); tick();
    chk("t1_acc_4", 64'(u_dut.acc_q), 64'hFFFF_FFE8);
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    drain = 1'b1;
    tick();
    chk("t1_psum_out", 64'(psum_out), 64'hFFFF_FFE8);
    chk("t1_psum_vld", 64'(psum_out_vld), 64'h1);
    chk("t1_acc_zero", 64'(u_dut.acc_q), 64'h0);
    chk("t1_state_drain", 64'(u_dut.state_q), 64'(ST_DRAIN));
    drain = 1'b0;
    tick();
    chk("t1_vld_drop", 64'(psum_out_vld), 64'h0);
    chk("t1_state_idle", 64'(u_dut.state_q), 64'(ST_IDLE));

    // OS bubbles: (5,5), invalid (9,9), (2,7) -> 39
    ops(8'd5, 1'b1, 8'd5, 1'b1);
    tick();
    ops(8'd9, 1'b0, 8'd9, 1'b0);
    tick();
    chk("t2_acc_hold", 64'(u_dut.acc_q), 64'd25);
    chk("t2_right_vld0", 64'(right_vld), 64'h0);
    ops(8'd2, 1'b1, 8'd7, 1'b1);
    tick();
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    drain = 1'b1;
    tick();
    chk("t2_psum_out", 64'(psum_out), 64'd39);
    chk("t2_psum_vld", 64'(psum_out_vld), 64'h1);
    drain = 1'b0;
    tick();

    // saturation vs wrap on 16-bit accumulators: 3 x (127,127)
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clear_state", 64'(u_dut.state_q), 64'(ST_IDLE));
    ops(8'd127, 1'b1, 8'd127, 1'b1);
    tick(); tick(); tick();
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    drain = 1'b1;
    tick();
    chk("t3_sat_psum", 64'(s_psum_out), 64'h7FFF);
    chk("t3_sat_ovf", 64'(s_ovf), 64'h1);
    chk("t3_wrap_psum", 64'(w_psum_out), 64'hBD03);
    chk("t3_wrap_ovf", 64'(w_ovf), 64'h1);
    chk("t3_wide_psum", 64'(psum_out), 64'd48387);
    chk("t3_wide_ovf", 64'(ovf), 64'h0);
    drain = 1'b0;
    tick();
    chk("t3_ovf_sticky", 64'(s_ovf), 64'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_sat_ovf_clr", 64'(s_ovf), 64'h0);
    chk("t3_wrap_ovf_clr", 64'(w_ovf), 64'h0);

    // drain chain: own acc 12, then 100, 200; operands during drain ignored
    ops(8'd3, 1'b1, 8'd4, 1'b1);
    tick();
    chk("t5_acc", 64'(u_dut.acc_q), 64'd12);
    drain = 1'b1;
    psum_in = 32'd100; psum_in_vld = 1'b1;
    ops(8'd5, 1'b1, 8'd5, 1'b1);
    tick();
    chk("t5_out_acc", 64'(psum_out), 64'd12);
    chk("t5_vld_acc", 64'(psum_out_vld), 64'h1);
    tick();
    chk("t5_out_100", 64'(psum_out), 64'd100);
    chk("t5_vld_100", 64'(psum_out_vld), 64'h1);
    psum_in = 32'd200;
    tick();
    chk("t5_out_200", 64'(psum_out), 64'd200);
    chk("t5_vld_200", 64'(psum_out_vld), 64'h1);
    drain = 1'b0; psum_in_vld = 1'b0;
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t5_vld_drop", 64'(psum_out_vld), 64'h0);
    chk("t5_state_idle", 64'(u_dut.state_q), 64'(ST_IDLE));
    chk("t5_acc_ignored", 64'(u_dut.acc_q), 64'h0);

    // WS: load weight 4, MAC, same-cycle reload uses old weight, bubble
    mode_ws = 1'b1;
    w_load = 1'b1;
    ops(8'd4, 1'b1, 8'h00, 1'b0);
    psum_in = '0;
    tick();
    chk("t4_wload_bvld", 64'(bottom_vld), 64'h0);
    chk("t4_wload_bout", 64'(bottom_out), 64'h04);
    w_load = 1'b0;
    ops(8'h00, 1'b0, 8'd3, 1'b1);
    psum_in = 32'd10; psum_in_vld = 1'b1;
    tick();
    chk("t4_mac_22", 64'(psum_out), 64'd22);
    chk("t4_mac_vld", 64'(psum_out_vld), 64'h1);
    w_load = 1'b1;
    ops(8'd6, 1'b1, 8'd3, 1'b1);
    tick();
    chk("t4_old_weight", 64'(psum_out), 64'd22);
    chk("t4_reload_bvld", 64'(bottom_vld), 64'h0);
    w_load = 1'b0;
    ops(8'h00, 1'b0, 8'd3, 1'b1);
    tick();
    chk("t4_new_weight", 64'(psum_out), 64'd28);
    ops(8'h00, 1'b0, 8'hFF, 1'b1);
    tick();
    chk("t4_neg_left", 64'(psum_out), 64'd4);
    chk("t4_neg_left16", 64'(s_psum_out), 64'd4);
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    psum_in = 32'd55;
    tick();
    chk("t4_bubble_val", 64'(psum_out), 64'd55);
    chk("t4_bubble_vld", 64'(psum_out_vld), 64'h0);
    psum_in = '0; psum_in_vld = 1'b0;
    mode_ws = 1'b0;
    tick();

    // async reset mid-ACC, then clear & drain together
    ops(8'd2, 1'b1, 8'd3, 1'b1);
    tick(); tick();
    chk("t6_state_acc", 64'(u_dut.state_q), 64'(ST_ACC));
    chk("t6_acc_12", 64'(u_dut.acc_q), 64'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_psum", 64'(psum_out), 64'h0);
    chk("t6_rst_right_vld", 64'(right_vld), 64'h0);
    chk("t6_rst_state", 64'(u_dut.state_q), 64'(ST_IDLE));
    chk("t6_rst_acc", 64'(u_dut.acc_q), 64'h0);
    chk("t6_rst_weight", 64'(u_dut.weight_q), 64'h0);
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ops(8'd2, 1'b1, 8'd3, 1'b1);
    tick();
    chk("t6_acc_6", 64'(u_dut.acc_q), 64'd6);
    ops(8'h00, 1'b0, 8'h00, 1'b0);
    clear = 1'b1; drain = 1'b1;
    tick();
    chk("t6_cd_vld", 64'(psum_out_vld), 64'h0);
    chk("t6_cd_psum", 64'(psum_out), 64'h0);
    chk("t6_cd_acc", 64'(u_dut.acc_q), 64'h0);
    chk("t6_cd_state", 64'(u_dut.state_q), 64'(ST_IDLE));
    clear = 1'b0;
    tick();
    chk("t6_late_drain_vld", 64'(psum_out_vld), 64'h1);
    chk("t6_late_drain_val", 64'(psum_out), 64'h0);
    chk("t6_late_state", 64'(u_dut.state_q), 64'(ST_DRAIN));
    drain = 1'b0;
    tick();
    chk("t6_end_vld", 64'(psum_out_vld), 64'h0);
    chk("end_ovf", 64'(ovf), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
